// File: rtl/dmem_cache_responder_pkg.sv
// Shared definitions for the MEM-stage data cache responder: FSM state
// encoding, bus widths and small address helpers.
package dmem_cache_responder_pkg;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int DEF_INDEX_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_WR_DONE = 2'd3
    } state_e;

    // Tag width left over once the byte offset and index are removed.
    function automatic int tag_bits(input int index_bits);
        return ADDR_W - index_bits - 2;
    endfunction

    // Backing memory is word addressed; byte offset is forced to zero.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_cache_responder_if.sv
// CPU-side and backing-memory-side signals of the data cache responder.
// slave  : the responder's view.
// master : the view of whatever drives the CPU requests and the memory.
interface dmem_cache_responder_if;

    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    modport slave (
        input  addr_i, wdata_i, MemRead_i, MemWrite_i, mem_rdata_i, mem_ack_i,
        output rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output addr_i, wdata_i, MemRead_i, MemWrite_i, mem_rdata_i, mem_ack_i,
        input  rdata_o, stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/dmem_cache_responder_line_array.sv
// Direct-mapped one-word-per-line storage. Valid bits clear asynchronously
// on reset; tag and data arrays hold their contents (they are meaningless
// until the valid bit is set). One combinational read port, one write port:
// a line write sets valid, tag and data; a data-only write updates the word.
module dcache_line_array #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_W      = 26
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_W-1:0]      o_rd_tag,
    output logic [31:0]           o_rd_data,
    input  logic                  i_wr_en,
    input  logic                  i_wr_line,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic [31:0]           i_wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    // Valid bits: cleared by reset, set by a refill line write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= {LINES{1'b0}};
        end else if (i_wr_en && i_wr_line) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag array: only refills change the tag.
    always_ff @(posedge clk_i) begin
        if (i_wr_en && i_wr_line) begin
            r_tag[i_wr_index] <= i_wr_tag;
        end
    end

    // Data array: written by refills and by write-through store hits.
    always_ff @(posedge clk_i) begin
        if (i_wr_en) begin
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/dmem_cache_responder.sv
// MEM-stage data responder: direct-mapped, write-through, no-write-allocate
// word cache in front of a variable-latency memory port. Read hits finish
// in the request cycle; misses and all stores stall the pipeline until the
// memory acknowledges. Stores retire in a one-cycle WR_DONE state.
module dmem_cache_responder
    import dmem_cache_responder_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    dmem_cache_responder_if.slave   bus
);

    localparam int TAG_W = tag_bits(INDEX_BITS);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [31:0]           r_mem_addr;
    logic [31:0]           w_mem_addr_nxt;
    logic [31:0]           r_mem_wdata;
    logic [31:0]           w_mem_wdata_nxt;
    logic                  r_mem_we;
    logic                  w_mem_we_nxt;

    logic [29:0]           w_lookup_word;
    logic [INDEX_BITS-1:0] w_rd_index;
    logic [TAG_W-1:0]      w_lookup_tag;
    logic                  w_line_valid;
    logic [TAG_W-1:0]      w_line_tag;
    logic [31:0]           w_line_data;
    logic                  w_hit;

    logic                  w_wr_en;
    logic                  w_wr_line;
    logic [31:0]           w_wr_data;
    logic [INDEX_BITS-1:0] w_wr_index;
    logic [TAG_W-1:0]      w_wr_tag;

    logic                  w_stall;
    logic                  w_mem_req;
    logic [31:0]           w_rdata;

    // Lookup address: the pending store's address while waiting on its ack
    // (write-through hit test), otherwise the live CPU address.
    always_comb begin
        if (r_state == ST_WR_WAIT) begin
            w_lookup_word = r_mem_addr[31:2];
        end else begin
            w_lookup_word = bus.addr_i[31:2];
        end
    end

    assign w_rd_index   = w_lookup_word[INDEX_BITS-1:0];
    assign w_lookup_tag = w_lookup_word[29:INDEX_BITS];
    assign w_hit        = w_line_valid && (w_line_tag == w_lookup_tag);

    // Refills and store updates always target the registered request address.
    assign w_wr_index = r_mem_addr[INDEX_BITS+1:2];
    assign w_wr_tag   = r_mem_addr[31:INDEX_BITS+2];

    dcache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_rd_index (w_rd_index),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_wr_en    (w_wr_en),
        .i_wr_line  (w_wr_line),
        .i_wr_index (w_wr_index),
        .i_wr_tag   (w_wr_tag),
        .i_wr_data  (w_wr_data)
    );

    // Next-state, request capture, array write control and stall decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_we_nxt    = r_mem_we;
        w_wr_en         = 1'b0;
        w_wr_line       = 1'b0;
        w_wr_data       = r_mem_wdata;
        w_stall         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Store wins if both requests are (illegally) raised together.
                if (bus.MemWrite_i) begin
                    w_state_nxt     = ST_WR_WAIT;
                    w_mem_addr_nxt  = word_align(bus.addr_i);
                    w_mem_wdata_nxt = bus.wdata_i;
                    w_mem_we_nxt    = 1'b1;
                    w_stall         = 1'b1;
                end else if (bus.MemRead_i && !w_hit) begin
                    w_state_nxt    = ST_RD_WAIT;
                    w_mem_addr_nxt = word_align(bus.addr_i);
                    w_mem_we_nxt   = 1'b0;
                    w_stall        = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                w_stall = 1'b1;
                if (bus.mem_ack_i) begin
                    w_wr_en     = 1'b1;
                    w_wr_line   = 1'b1;
                    w_wr_data   = bus.mem_rdata_i;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RD_WAIT;
                end
            end
            ST_WR_WAIT: begin
                w_stall = 1'b1;
                if (bus.mem_ack_i) begin
                    w_state_nxt = ST_WR_DONE;
                    // Update only a resident line; misses do not allocate.
                    if (w_hit) begin
                        w_wr_en   = 1'b1;
                        w_wr_line = 1'b0;
                        w_wr_data = r_mem_wdata;
                    end else begin
                        w_wr_en = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_WR_WAIT;
                end
            end
            ST_WR_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and memory-request registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_wdata <= 32'h0000_0000;
            r_mem_we    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_we    <= w_mem_we_nxt;
        end
    end

    // Memory request is a pure decode of the registered state, so it drops
    // as soon as reset forces the state back to IDLE.
    always_comb begin
        if ((r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT)) begin
            w_mem_req = 1'b1;
        end else begin
            w_mem_req = 1'b0;
        end
    end

    // Load data: the addressed word on a hit, zero otherwise.
    always_comb begin
        if (w_hit) begin
            w_rdata = w_line_data;
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    assign bus.rdata_o     = w_rdata;
    assign bus.stall_o     = w_stall;
    assign bus.mem_req_o   = w_mem_req;
    assign bus.mem_we_o    = r_mem_we;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_dmem_cache_responder.sv
// Self-checking bench for dmem_cache_responder: table of CPU operations with
// expected stall length / load data, a backing-memory model with programmable
// ack latency, and a scoreboard of expected memory transactions.
`timescale 1ns/1ps
module tb_dmem_cache_responder;
    import dmem_cache_responder_pkg::*;

    logic clk;
    logic rst;

    dmem_cache_responder_if bus();

    dmem_cache_responder #(.INDEX_BITS(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_stall;
        logic        exp_txn;
        logic [31:0] exp_rdata;
    } vec_t;

    txn_t        exp_q[$];
    txn_t        cur_txn;
    logic        cur_valid = 1'b0;
    logic [31:0] mem_model [logic [31:0]];
    int          lat_cfg   = 1;
    int          wait_cnt;
    logic [31:0] mem_rdata_drv = 32'h0;
    vec_t        vecs[14];

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: ack after lat_cfg request cycles (1 = first request cycle).
    assign bus.mem_ack_i   = bus.mem_req_o && (wait_cnt == lat_cfg - 1);
    assign bus.mem_rdata_i = mem_rdata_drv;

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (bus.mem_req_o && !bus.mem_ack_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // Scoreboard/monitor: check each new request against the expected queue,
    // check its attributes stay stable, supply read data and commit writes.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.mem_req_o) begin
                if (wait_cnt == 0) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        cur_valid = 1'b0;
                        $display("FAIL unexpected_txn: got we=%0b addr=%h expected none", bus.mem_we_o, bus.mem_addr_o);
                    end else begin
                        cur_txn   = exp_q.pop_front();
                        cur_valid = 1'b1;
                        check_val("txn_we", {31'd0, bus.mem_we_o}, {31'd0, cur_txn.we});
                        check_val("txn_addr", bus.mem_addr_o, cur_txn.addr);
                        if (cur_txn.we) check_val("txn_wdata", bus.mem_wdata_o, cur_txn.wdata);
                    end
                end else if (cur_valid) begin
                    check_val("txn_addr_hold", bus.mem_addr_o, cur_txn.addr);
                end
                if (!bus.mem_we_o) mem_rdata_drv = mem_lookup(bus.mem_addr_o);
                if (bus.mem_ack_i && bus.mem_we_o) mem_model[bus.mem_addr_o] = bus.mem_wdata_o;
            end
        end
    end

    // Apply one CPU operation (entered just after a rising edge) and check it.
    task automatic do_op(input vec_t v, input string tag);
        int stalls;
        bit seen_req;
        bit done;
        txn_t t;
        lat_cfg        = v.lat;
        bus.MemRead_i  = v.rd;
        bus.MemWrite_i = v.wr;
        bus.addr_i     = v.addr;
        bus.wdata_i    = v.wdata;
        if (v.exp_txn) begin
            t.we    = v.wr;
            t.addr  = {v.addr[31:2], 2'b00};
            t.wdata = v.wdata;
            exp_q.push_back(t);
        end
        stalls   = 0;
        seen_req = 1'b0;
        done     = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (bus.mem_req_o) seen_req = 1'b1;
            if (bus.stall_o) stalls++;
            else done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: got stall after 60 cycles expected release", tag);
        end
        check_val({tag, "_stall_cycles"}, stalls, v.exp_stall);
        check_val({tag, "_mem_req_seen"}, {31'd0, seen_req}, {31'd0, v.exp_txn});
        if (v.rd && !v.wr) check_val({tag, "_rdata"}, bus.rdata_o, v.exp_rdata);
        @(posedge clk);
        #1;
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
    endtask

    initial begin
        vec_t v;
        //            rd    wr    addr          wdata         lat stall txn   exp_rdata
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         3, 4, 1'b1, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         3, 0, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 2, 3, 1'b1, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0041, 32'h0,         1, 0, 1'b0, 32'h1234_5678};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0440, 32'hCAFE_F00D, 1, 2, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1, 0, 1'b0, 32'h1234_5678};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0440, 32'h0,         2, 3, 1'b1, 32'hCAFE_F00D};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1, 2, 1'b1, 32'h1234_5678};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h0BAD_F00D, 2, 3, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1, 2, 1'b1, 32'h0BAD_F00D};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         4, 5, 1'b1, 32'h5A5A_0044};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_007E, 32'h0,         1, 2, 1'b1, 32'h5A5A_007C};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         1, 0, 1'b0, 32'h5A5A_0044};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1, 0, 1'b0, 32'h0BAD_F00D};

        mem_model[32'h0000_0040] = 32'hDEAD_BEEF;

        rst            = 1'b1;
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b0;
        bus.addr_i     = 32'h0;
        bus.wdata_i    = 32'h0;
        repeat (2) @(negedge clk);
        check_val("rst_mem_req",   {31'd0, bus.mem_req_o}, 32'h0);
        check_val("rst_mem_we",    {31'd0, bus.mem_we_o},  32'h0);
        check_val("rst_mem_addr",  bus.mem_addr_o,  32'h0);
        check_val("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
        check_val("rst_stall",     {31'd0, bus.stall_o},   32'h0);
        check_val("rst_rdata",     bus.rdata_o,     32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a refill: request must drop at once and the
        // cache must come back empty.
        lat_cfg        = 20;
        bus.addr_i     = 32'h0000_0080;
        bus.MemRead_i  = 1'b1;
        bus.MemWrite_i = 1'b0;
        begin
            txn_t t;
            t.we    = 1'b0;
            t.addr  = 32'h0000_0080;
            t.wdata = 32'h0;
            exp_q.push_back(t);
        end
        @(negedge clk);
        check_val("mid_rst_req_stall", {31'd0, bus.stall_o}, 32'h1);
        @(negedge clk);
        check_val("mid_rst_req_high", {31'd0, bus.mem_req_o}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_req_async_drop", {31'd0, bus.mem_req_o}, 32'h0);
        bus.MemRead_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        v = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 2, 1'b1, 32'h1234_5678};
        do_op(v, "post_rst_rd40");

        repeat (2) @(negedge clk);
        check_val("scoreboard_empty", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
